// File: rtl/generic_divider.sv
// ---------------------------------------------------------------------------
// generic_divider
//
// Sequential restoring shift-and-subtract divider. Computes the unsigned
// WIDTH-bit quotient and remainder of dividend / divisor, retiring one
// quotient bit per clock through a single (WIDTH+1)-bit subtractor.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-high reset (wins over load)
//   load         start pulse: captures dividend/divisor, (re)starts
//   dividend     unsigned dividend, sampled when load=1
//   divisor      unsigned divisor, sampled when load=1
//   quotient     registered quotient, meaningful only while valid=1
//   remainder    registered remainder, meaningful only while valid=1
//   valid        result ready, held until the next load or rst
//   busy         high while iterations are in progress
//   div_by_zero  high together with valid when the captured divisor was 0
//   state_dbg    current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Handshake: load is sampled on every rising edge with rst=0. The edge that
// samples load drops valid; for a non-zero divisor valid rises exactly WIDTH
// edges later (busy is high in between), for a zero divisor one edge later.
// A load while busy aborts the running operation without a valid pulse.
// ---------------------------------------------------------------------------
module generic_divider #(
  parameter  int WIDTH = 128,
  localparam int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid,
  output logic             busy,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd_sr;       // dividend bits still to be consumed, MSB first
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] partial_rem;
  logic [CNTW-1:0]  cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] next_rem;
  logic             last_iter;

  // partial_rem < divisor always holds, so shifted <= 2*divisor-1 and the
  // extra top bit of trial is a clean borrow flag.
  always_comb begin
    shifted   = {partial_rem, dvd_sr[WIDTH-1]};
    trial     = shifted - {1'b0, divisor_r};
    qbit      = ~trial[WIDTH];
    next_rem  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    last_iter = (cnt == CNTW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dvd_sr      <= '0;
      divisor_r   <= '0;
      partial_rem <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (load) begin
      dvd_sr      <= dividend;
      divisor_r   <= divisor;
      partial_rem <= '0;
      quotient    <= '0;
      cnt         <= '0;
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
      // A zero divisor also passes through RUN for one edge, but without
      // raising busy; RUN resolves it immediately.
      busy        <= (divisor != '0);
      state       <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (divisor_r == '0) begin
            quotient    <= '1;
            remainder   <= dvd_sr;
            div_by_zero <= 1'b1;
            valid       <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_DONE;
          end else begin
            partial_rem <= next_rem;
            quotient    <= {quotient[WIDTH-2:0], qbit};
            dvd_sr      <= {dvd_sr[WIDTH-2:0], 1'b0};
            cnt         <= cnt + CNTW'(1);
            if (last_iter) begin
              remainder <= next_rem;
              valid     <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_DONE;
            end
          end
        end
        default: ; // IDLE and DONE hold everything until load or rst
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/generic_divider.md
Name: generic_divider

Overview:
- Sequential restoring shift-and-subtract divider; the inverse companion of the team's shift-and-add multiplier.
- Computes an unsigned WIDTH-bit quotient and remainder, producing one quotient bit per clock.
- Uses a single (WIDTH+1)-bit subtractor instead of a 2*WIDTH-bit datapath, for area.
- Sits beside the multiplier in the arithmetic unit and uses the same load/valid protocol.

Parameters:
- WIDTH, 128, operand width in bits for dividend, divisor, quotient and remainder (>= 2).
- CNTW, $clog2(WIDTH+1), iteration counter width (derived; not to be overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  start pulse; captures dividend/divisor and (re)starts the operation
- dividend  input  WIDTH  unsigned dividend, sampled when load=1
- divisor  input  WIDTH  unsigned divisor, sampled when load=1
- quotient  output  WIDTH  unsigned quotient, registered; meaningful only while valid=1
- remainder  output  WIDTH  unsigned remainder, registered; meaningful only while valid=1
- valid  output  1  result ready; held high until the next load or rst
- busy  output  1  high while iterations are in progress
- div_by_zero  output  1  high with valid when the captured divisor was 0

Behaviour:
- Reset (rst=1 at an edge):
  - quotient, remainder, valid, busy, div_by_zero, counter and all internal registers go to 0.
  - rst has priority over load.
- State machine: IDLE, RUN, DONE.
  - IDLE: entered from reset; waits for load.
  - load=1 in any state (rst=0):
    - Capture dividend into the shift register and divisor into the divisor register.
    - Clear the partial remainder, quotient, counter, valid and div_by_zero.
    - If divisor==0, go to DONE at the next edge (see divide by zero below).
    - Otherwise set busy=1 and go to RUN.
    - A load during RUN aborts the current operation; no valid pulse is produced for it.
- RUN, per edge (iterations k = 1..WIDTH):
  - shifted = {partial_rem[WIDTH-1:0], dvd_sr[WIDTH-1]}, WIDTH+1 bits.
  - trial = shifted - {1'b0, divisor}, WIDTH+1-bit subtraction.
  - If trial is non-negative (no borrow): partial_rem <= trial[WIDTH-1:0] and quotient bit = 1.
  - Otherwise: partial_rem <= shifted[WIDTH-1:0] and quotient bit = 0.
  - Shift the quotient bit into the quotient LSB (quotient <= {quotient[WIDTH-2:0], qbit}).
  - dvd_sr shifts left by 1; counter increments.
  - The partial remainder is always < divisor, so a WIDTH-bit remainder never overflows. The (WIDTH+1)-bit compare is required because shifted can reach 2*divisor-1.
- Completion:
  - On the edge performing iteration WIDTH: valid <= 1, busy <= 0, remainder <= final partial_rem, state -> DONE.
  - valid rises exactly WIDTH edges after the edge that sampled load.
- DONE: outputs hold with valid=1 until load or rst.
- Divide by zero:
  - At the edge after the load edge: quotient = all ones, remainder = captured dividend, div_by_zero=1, valid=1, busy=0.
  - Latency is 1 cycle.
- While busy=1, quotient/remainder hold intermediate values; consumers must ignore them.
- load held high across several edges re-captures the inputs every edge. The operation starts from the last edge on which load was high.

Test Plan:
- WIDTH=8, load 200/7 -> busy for 8 cycles; at the 8th edge after load: valid=1, quotient=28, remainder=4, div_by_zero=0.
- WIDTH=8, back-to-back loads:
  - 255/1 -> q=255, r=0.
  - then 5/9 -> q=0, r=5.
  - then 255/255 -> q=1, r=0.
  - valid drops on each load edge and rises 8 edges later.
- WIDTH=8, load 77/0 -> next edge: valid=1, div_by_zero=1, quotient=0xFF, remainder=77, busy=0.
- WIDTH=8, load 200/7, then at the 3rd edge load 100/10 -> no valid for the first operation; q=10, r=0 valid 8 edges after the second load.
- WIDTH=8, load 200/7, then rst at the 4th edge (with load=1 simultaneously) -> all outputs 0 at the next edge; stays IDLE; no valid.
- WIDTH=128:
  - (2^128-1)/2^127 -> q=1, r=2^127-1.
  - (2^128-1)/(2^128-1) -> q=1, r=0.
  - 1000 random pairs (divisor != 0) checked against a golden model; valid always 128 edges after load.
